// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: queues per-key press/release edges and services one
// per cycle, assigning presses to free voices or stealing the oldest voice.
module voice_allocator #(
  parameter int NUM_KEYS   = 24,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 5
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [NUM_KEYS-1:0]           gate_in,
  output logic [NUM_VOICES-1:0]         voice_gate_out,
  output logic [NUM_VOICES-1:0]         voice_trigger_out,
  output logic [NUM_VOICES*KEY_W-1:0]   voice_key_out,
  output logic                          steal_out,
  output logic                          busy_out
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0] gate_prev, pend_on, pend_off;
  logic [NUM_KEYS-1:0] on, off, svc_on_mask, svc_off_mask, pend_on_left;
  logic [NUM_KEYS-1:0] pend_on_next, pend_off_next;
  logic                svc_valid, svc_release;
  logic [KEY_W-1:0]    svc_key;
  logic [NUM_VOICES-1:0] rel_hit;
  logic [VW-1:0]       alloc_voice;
  logic                free_found;
  logic [2:0]          age [NUM_VOICES];

  assign on  = gate_in & ~gate_prev;
  assign off = ~gate_in & gate_prev;
  assign busy_out = (|pend_on) | (|pend_off);

  // Releases first; the downward scan leaves the lowest set index in svc_key.
  always_comb begin
    svc_valid    = 1'b0;
    svc_release  = 1'b0;
    svc_key      = '0;
    svc_on_mask  = '0;
    svc_off_mask = '0;
    if (|pend_off) begin
      svc_valid   = 1'b1;
      svc_release = 1'b1;
      for (int unsigned k = NUM_KEYS; k > 0; k--)
        if (pend_off[k-1]) svc_key = KEY_W'(k-1);
      svc_off_mask = NUM_KEYS'(1) << svc_key;
    end else if (|pend_on) begin
      svc_valid = 1'b1;
      for (int unsigned k = NUM_KEYS; k > 0; k--)
        if (pend_on[k-1]) svc_key = KEY_W'(k-1);
      svc_on_mask = NUM_KEYS'(1) << svc_key;
    end
  end

  // A release cancels a press still waiting in the queue; a press being serviced
  // this cycle is no longer waiting, so its release is queued normally.
  always_comb begin
    pend_on_left  = pend_on & ~svc_on_mask;
    pend_on_next  = (pend_on_left | on) & ~(off & pend_on_left);
    pend_off_next = (pend_off & ~svc_off_mask) | (off & ~pend_on_left);
  end

  always_comb begin
    rel_hit     = '0;
    free_found  = 1'b0;
    alloc_voice = '0;
    for (int unsigned v = 0; v < NUM_VOICES; v++)
      rel_hit[v] = voice_gate_out[v] && (voice_key_out[KEY_W*v +: KEY_W] == svc_key);
    for (int unsigned v = NUM_VOICES; v > 0; v--)
      if (!voice_gate_out[v-1]) begin
        alloc_voice = VW'(v-1);
        free_found  = 1'b1;
      end
    if (!free_found)
      for (int unsigned v = 0; v < NUM_VOICES; v++)
        if (age[v] == 3'(NUM_VOICES-1)) alloc_voice = VW'(v);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gate_prev         <= '0;
      pend_on           <= '0;
      pend_off          <= '0;
      voice_gate_out    <= '0;
      voice_trigger_out <= '0;
      voice_key_out     <= '0;
      steal_out         <= 1'b0;
      for (int unsigned v = 0; v < NUM_VOICES; v++) age[v] <= 3'(v);
    end else begin
      gate_prev         <= gate_in;
      pend_on           <= pend_on_next;
      pend_off          <= pend_off_next;
      voice_trigger_out <= '0;
      steal_out         <= 1'b0;
      if (svc_valid && svc_release) begin
        voice_gate_out <= voice_gate_out & ~rel_hit;
      end else if (svc_valid) begin
        voice_gate_out[alloc_voice]                 <= 1'b1;
        voice_trigger_out[alloc_voice]              <= 1'b1;
        voice_key_out[KEY_W*alloc_voice +: KEY_W]   <= svc_key;
        steal_out                                   <= !free_found;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
          if (VW'(v) == alloc_voice) age[v] <= '0;
          else if (age[v] < age[alloc_voice]) age[v] <= 3'(age[v] + 3'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: expected triggers are queued with their cycle
// when stimulus is applied and matched against the DUT as it produces them.
module tb_voice_allocator;
  localparam int NK = 24;
  localparam int NV = 4;
  localparam int KW = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NK-1:0]    gate = '0;
  logic [NV-1:0]    voice_gate, trigger;
  logic [NV*KW-1:0] voice_key;
  logic             steal, busy;

  typedef struct {
    int cyc;
    int v;
    int key;
    bit steal;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int base;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
    .clk_in(clk), .rst_in(rst), .gate_in(gate),
    .voice_gate_out(voice_gate), .voice_trigger_out(trigger),
    .voice_key_out(voice_key), .steal_out(steal), .busy_out(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int at, input int v, input int key, input bit s);
    exp_t e;
    e.cyc = at; e.v = v; e.key = key; e.steal = s;
    exp_q.push_back(e);
  endtask

  // Advance one clock and compare any trigger activity against the scoreboard.
  task automatic tick();
    exp_t e;
    logic [KW-1:0] k;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      k = voice_key[KW*e.v +: KW];
      chk("trigger_vec", 32'(trigger), 32'(1) << e.v);
      chk("trigger_key", 32'(k), 32'(e.key));
      chk("trigger_steal", 32'(steal), 32'(e.steal));
    end else begin
      chk("idle_trigger", {27'b0, steal, trigger}, 32'd0);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset with all keys held
    gate = 24'hFFFFFF;
    tick();
    chk("rst_gate", 32'(voice_gate), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    chk("rst_key", 32'(voice_key), 32'd0);
    chk("rst_busy2", 32'(busy), 32'd0);
    chk("rst_steal", 32'(steal), 32'd0);
    rst = 1'b0;
    base = cyc;
    for (int k = 0; k < NK; k++) push(base + 2 + k, k % NV, k, k >= NV);
    tick();
    chk("held_busy", 32'(busy), 32'd1);
    ticks(25);
    chk("held_gates", 32'(voice_gate), 32'hF);
    for (int v = 0; v < NV; v++) chk("held_keys", 32'(voice_key[KW*v +: KW]), 32'(20 + v));
    chk("held_idle", 32'(busy), 32'd0);
    gate = '0;
    ticks(26);
    chk("held_release", 32'(voice_gate), 32'd0);
    chk("held_release_busy", 32'(busy), 32'd0);

    // Single note
    gate[5] = 1'b1;
    push(cyc + 2, 0, 5, 1'b0);
    tick();
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    chk("single_gate", 32'(voice_gate), 32'h1);
    chk("single_key", 32'(voice_key[KW*0 +: KW]), 32'd5);
    tick();
    chk("single_trig_once", 32'(trigger), 32'd0);
    gate[5] = 1'b0;
    ticks(2);
    chk("single_off", 32'(voice_gate), 32'd0);
    chk("single_key_hold", 32'(voice_key[KW*0 +: KW]), 32'd5);

    // Simultaneous presses
    gate = 24'h000288;
    base = cyc;
    push(base + 2, 0, 3, 1'b0);
    push(base + 3, 1, 7, 1'b0);
    push(base + 4, 2, 9, 1'b0);
    tick();
    chk("simul_busy_n", 32'(busy), 32'd1);
    tick();
    chk("simul_busy_n1", 32'(busy), 32'd1);
    tick();
    chk("simul_busy_n2", 32'(busy), 32'd1);
    tick();
    chk("simul_busy_n3", 32'(busy), 32'd0);
    chk("simul_gates", 32'(voice_gate), 32'h7);
    gate = '0;
    ticks(5);
    chk("simul_off", 32'(voice_gate), 32'd0);

    // Steal of the oldest voice
    for (int k = 0; k < 4; k++) begin
      gate[k] = 1'b1;
      push(cyc + 2, k, k, 1'b0);
      ticks(10);
    end
    chk("steal_full", 32'(voice_gate), 32'hF);
    gate[10] = 1'b1;
    push(cyc + 2, 0, 10, 1'b1);
    ticks(3);
    chk("steal_gates", 32'(voice_gate), 32'hF);
    chk("steal_key", 32'(voice_key[KW*0 +: KW]), 32'd10);
    gate[0] = 1'b0;
    ticks(4);
    chk("stolen_release_gates", 32'(voice_gate), 32'hF);
    chk("stolen_release_key", 32'(voice_key[KW*0 +: KW]), 32'd10);
    gate = '0;
    ticks(6);
    chk("steal_off", 32'(voice_gate), 32'd0);

    // Dropped note: key 2 released before it is serviced
    gate = 24'h000006;
    push(cyc + 2, 0, 1, 1'b0);
    tick();
    gate[2] = 1'b0;
    ticks(5);
    chk("drop_gates", 32'(voice_gate), 32'h1);
    chk("drop_busy", 32'(busy), 32'd0);
    gate = '0;
    ticks(3);
    chk("drop_off", 32'(voice_gate), 32'd0);

    // Release takes priority over a simultaneous press
    gate = 24'h00002E;
    base = cyc;
    push(base + 2, 0, 1, 1'b0);
    push(base + 3, 1, 2, 1'b0);
    push(base + 4, 2, 3, 1'b0);
    push(base + 5, 3, 5, 1'b0);
    ticks(6);
    chk("prio_full", 32'(voice_gate), 32'hF);
    gate[2]  = 1'b0;
    gate[12] = 1'b1;
    push(cyc + 3, 1, 12, 1'b0);
    ticks(2);
    chk("prio_freed", 32'(voice_gate), 32'hD);
    tick();
    chk("prio_taken", 32'(voice_gate), 32'hF);
    gate = '0;
    ticks(6);
    chk("prio_off", 32'(voice_gate), 32'd0);

    // Reset while a backlog is draining
    gate = 24'hFFFFFF;
    push(cyc + 2, 0, 0, 1'b0);
    ticks(2);
    chk("drain_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_gate", 32'(voice_gate), 32'd0);
    chk("midrst_key", 32'(voice_key), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    gate = '0;
    rst  = 1'b0;
    ticks(3);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_gate", 32'(voice_gate), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
